// File: rtl/find_top_bottom_if.sv
// Pixel-memory read bus shared by the shape finders.
// Master drives the read address, slave returns pixel data one cycle later.
interface find_top_bottom_if #(
   parameter int addrSz = 12,
   parameter int colSz  = 3
);
   logic [addrSz-1:0] memAddr;
   logic [colSz-1:0]  pixVal;

   modport master (output memAddr, input pixVal);
   modport slave  (input memAddr, output pixVal);
endinterface

// File: rtl/find_top_bottom.sv
// Top/bottom finder: raster scan for top row, run midpoint, column walk down.
// Optional macro FTB_GAP_TOLERANCE_EN lets the walk bridge one black pixel.
module find_top_bottom #(
   parameter int xSz       = 6,
   parameter int ySz       = 6,
   parameter int addrSz    = 12,
   parameter int colSz     = 3,
   parameter int X_RES     = 60,
   parameter int Y_RES     = 60,
   parameter int THRESHOLD = 0
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   find_top_bottom_if.master mem,
   output logic [ySz-1:0]  mostTop,
   output logic [ySz-1:0]  mostBottom,
   output logic [xSz-1:0]  midPix,
   output logic            TopandBottomFound,
   output logic            notFound,
   output logic            busy
);

   typedef enum logic [3:0] {
      IDLE, RS_ADDR, RS_CHECK, RW_ADDR, RW_CHECK,
      CD_ADDR, CD_CHECK, DONE, NONE
   } state_t;

   state_t         r_state;
   logic [xSz-1:0] r_x;
   logic [ySz-1:0] r_y;
   logic [xSz-1:0] r_xFirst;
`ifdef FTB_GAP_TOLERANCE_EN
   logic           r_gap;
`endif

   logic           w_hit;
   logic           w_xEnd;
   logic           w_yEnd;
   logic           w_enterCd;
   logic [xSz-1:0] w_cdFirst;
   logic [xSz-1:0] w_cdLast;
   logic [xSz:0]   w_sum;
   logic [xSz-1:0] w_mid;

   function automatic logic [addrSz-1:0] f_addr(
      input logic [xSz-1:0] x,
      input logic [ySz-1:0] y
   );
      return addrSz'(y) * addrSz'(X_RES) + addrSz'(x);
   endfunction

   assign w_hit  = (mem.pixVal != colSz'(THRESHOLD));
   assign w_xEnd = (r_x == xSz'(X_RES - 1));
   assign w_yEnd = (r_y == ySz'(Y_RES - 1));

   // Leaving the top-row scan: run ends at image edge or at first black.
   assign w_enterCd =
      ((r_state == RS_CHECK) && w_hit && w_xEnd) ||
      ((r_state == RW_CHECK) && (!w_hit || w_xEnd));

   // A run that ends in RS_CHECK is one pixel wide, so xFirst is still r_x.
   assign w_cdFirst = (r_state == RS_CHECK) ? r_x : r_xFirst;
   assign w_cdLast  = (r_state == RW_CHECK && !w_hit) ? r_x - 1'b1 : r_x;
   assign w_sum     = {1'b0, w_cdFirst} + {1'b0, w_cdLast};
   assign w_mid     = w_sum[xSz:1];

   // Search FSM; all outputs, including the pulses, are registered here.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state           <= IDLE;
         r_x               <= '0;
         r_y               <= '0;
         r_xFirst          <= '0;
`ifdef FTB_GAP_TOLERANCE_EN
         r_gap             <= 1'b0;
`endif
         mem.memAddr       <= '0;
         mostTop           <= '0;
         mostBottom        <= '0;
         midPix            <= '0;
         TopandBottomFound <= 1'b0;
         notFound          <= 1'b0;
         busy              <= 1'b0;
      end else begin
         TopandBottomFound <= 1'b0;
         notFound          <= 1'b0;
         if (w_enterCd) begin
            if (r_state == RS_CHECK) begin
               r_xFirst <= r_x;
               mostTop  <= r_y;
            end
            midPix     <= w_mid;
            mostBottom <= r_y;
`ifdef FTB_GAP_TOLERANCE_EN
            r_gap      <= 1'b0;
`endif
            if (w_yEnd) begin
               TopandBottomFound <= 1'b1;
               r_state           <= DONE;
            end else begin
               r_x         <= w_mid;
               r_y         <= r_y + 1'b1;
               mem.memAddr <= f_addr(w_mid, r_y + 1'b1);
               r_state     <= CD_ADDR;
            end
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (start) begin
                     r_x         <= '0;
                     r_y         <= '0;
                     mem.memAddr <= '0;
                     busy        <= 1'b1;
                     r_state     <= RS_ADDR;
                  end
               end
               RS_ADDR: r_state <= RS_CHECK;
               RS_CHECK: begin
                  if (w_hit) begin
                     r_xFirst    <= r_x;
                     mostTop     <= r_y;
                     r_x         <= r_x + 1'b1;
                     mem.memAddr <= f_addr(r_x + 1'b1, r_y);
                     r_state     <= RW_ADDR;
                  end else if (w_xEnd && w_yEnd) begin
                     notFound <= 1'b1;
                     r_state  <= NONE;
                  end else if (w_xEnd) begin
                     r_x         <= '0;
                     r_y         <= r_y + 1'b1;
                     mem.memAddr <= f_addr('0, r_y + 1'b1);
                     r_state     <= RS_ADDR;
                  end else begin
                     r_x         <= r_x + 1'b1;
                     mem.memAddr <= f_addr(r_x + 1'b1, r_y);
                     r_state     <= RS_ADDR;
                  end
               end
               RW_ADDR: r_state <= RW_CHECK;
               RW_CHECK: begin
                  r_x         <= r_x + 1'b1;
                  mem.memAddr <= f_addr(r_x + 1'b1, r_y);
                  r_state     <= RW_ADDR;
               end
               CD_ADDR: r_state <= CD_CHECK;
               CD_CHECK: begin
                  if (w_hit) begin
                     mostBottom <= r_y;
`ifdef FTB_GAP_TOLERANCE_EN
                     r_gap      <= 1'b0;
`endif
                  end
`ifdef FTB_GAP_TOLERANCE_EN
                  if (!w_yEnd && (w_hit || !r_gap)) begin
                     if (!w_hit) r_gap <= 1'b1;
`else
                  if (!w_yEnd && w_hit) begin
`endif
                     r_y         <= r_y + 1'b1;
                     mem.memAddr <= f_addr(r_x, r_y + 1'b1);
                     r_state     <= CD_ADDR;
                  end else begin
                     TopandBottomFound <= 1'b1;
                     r_state           <= DONE;
                  end
               end
               DONE, NONE: begin
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_find_top_bottom.sv
// Scoreboard bench for find_top_bottom with a 60x60 image model.
// Stimulus pushes expected results; a negedge monitor pops on each pulse.
module tb_find_top_bottom;

   typedef struct {
      bit found;
      int top;
      int bot;
      int mid;
      int s;
      int p;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [5:0] mostTop;
   logic [5:0] mostBottom;
   logic [5:0] midPix;
   logic       TopandBottomFound;
   logic       notFound;
   logic       busy;

   logic [2:0] img [3600];
   exp_t       q[$];
   int         cyc = 0;
   int         maxAddr = 0;
   int         n_vec = 0;
   int         n_err = 0;

   find_top_bottom_if bus ();

   find_top_bottom dut (
      .clk               (clk),
      .resetn            (resetn),
      .start             (start),
      .mem               (bus.master),
      .mostTop           (mostTop),
      .mostBottom        (mostBottom),
      .midPix            (midPix),
      .TopandBottomFound (TopandBottomFound),
      .notFound          (notFound),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   // Synchronous read-only image RAM.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (int'(bus.memAddr) > maxAddr) maxAddr = int'(bus.memAddr);
      if (bus.memAddr < 12'd3600) bus.pixVal <= img[bus.memAddr];
      else bus.pixVal <= 3'd0;
   end

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: every result pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      if (resetn && (TopandBottomFound || notFound)) begin
         if (q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("found_pulse", int'(TopandBottomFound), int'(e.found));
            check("notfound_pulse", int'(notFound), int'(!e.found));
            check("mostTop", int'(mostTop), e.top);
            check("mostBottom", int'(mostBottom), e.bot);
            check("midPix", int'(midPix), e.mid);
            check("latency", cyc - e.s, 2 * e.p);
         end
      end
   end

   task automatic clear_img();
      for (int i = 0; i < 3600; i++) img[i] = 3'd0;
   endtask

   task automatic set_px(input int x, input int y, input logic [2:0] v);
      img[y * 60 + x] = v;
   endtask

   task automatic block1();
      clear_img();
      for (int y = 5; y <= 7; y++)
         for (int x = 10; x <= 12; x++) set_px(x, y, 3'd5);
   endtask

   task automatic run(input bit found, input int top, input int bot,
                      input int mid, input int p, input bit chk);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      e.found = found;
      e.top = top;
      e.bot = bot;
      e.mid = mid;
      e.s = cyc;
      e.p = p;
      start = 1'b0;
      if (chk) begin
         q.push_back(e);
         for (int i = 0; i < 8000 && q.size() != 0; i++) @(posedge clk);
         if (q.size() != 0) begin
            check("timeout", 0, 1);
            q.delete();
         end
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic check_reset_outs();
      check("rst_memAddr", int'(bus.memAddr), 0);
      check("rst_mostTop", int'(mostTop), 0);
      check("rst_mostBottom", int'(mostBottom), 0);
      check("rst_midPix", int'(midPix), 0);
      check("rst_found", int'(TopandBottomFound), 0);
      check("rst_notFound", int'(notFound), 0);
      check("rst_busy", int'(busy), 0);
   endtask

   initial begin
      int p1;
      int bgap;
      int pgap;
`ifdef FTB_GAP_TOLERANCE_EN
      p1 = 318;
      bgap = 7;
      pgap = 318;
`else
      p1 = 317;
      bgap = 5;
      pgap = 315;
`endif
      clear_img();
      repeat (3) @(negedge clk);
      check_reset_outs();
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // All black: whole raster, notFound, results untouched.
      run(1'b0, 0, 0, 0, 3600, 1'b1);

      // 3x3 block at x=10..12, y=5..7.
      block1();
      run(1'b1, 5, 7, 11, p1, 1'b1);

      // Abort mid-raster, then a clean search.
      run(1'b1, 0, 0, 0, 0, 1'b0);
      repeat (150) @(negedge clk);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outs();
      @(negedge clk);
      check_reset_outs();
      resetn = 1'b1;
      @(negedge clk);
      fork
         begin
            repeat (60) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join_none
      run(1'b1, 5, 7, 11, p1, 1'b1);

      // Gap in column 11 at y=6.
      block1();
      set_px(11, 6, 3'd0);
      run(1'b1, 5, bgap, 11, pgap, 1'b1);

      // Single pixel in the last image corner.
      clear_img();
      set_px(59, 59, 3'd1);
      maxAddr = 0;
      run(1'b1, 59, 59, 59, 3600, 1'b1);
      check("max_addr", maxAddr, 3599);

      // Full top row plus full column 29.
      clear_img();
      for (int x = 0; x < 60; x++) set_px(x, 0, 3'd7);
      for (int y = 0; y < 60; y++) set_px(29, y, 3'd2);
      run(1'b1, 0, 59, 29, 119, 1'b1);
      check("idle_busy", int'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
